alu_ctrl_fsm: RTL and testbench

- Multi-cycle control unit that drives the 8-bit ALU's opcode input and consumes its Zero flag.
- Fetches 16-bit instructions over a valid/ready handshake and decodes the 4-bit opcode.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB and generates register-file, data-memory and PC controls.
- Sits between instruction memory, data memory, register file and ALU in the single-cycle datapath's multi-cycle successor.

---
 rtl/alu_ctrl_fsm_if.sv | 36 +++
 rtl/alu_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_fsm_if.sv
// Control bundle between alu_ctrl_fsm and the instruction memory, data memory,
// register file and ALU.
interface alu_ctrl_fsm_if #(
    parameter int unsigned PC_W = 8
) ();
    logic            InstrReq;
    logic [PC_W-1:0] InstrAddr;
    logic            InstrValid;
    logic [15:0]     Instr;
    logic            Zero;
    logic [3:0]      ALUControl;
    logic            RegWrite;
    logic [1:0]      RdAddr;
    logic [1:0]      RsAddr;
    logic [7:0]      Imm;
    logic            MemRead;
    logic            MemWrite;
    logic            MemAck;
    logic            MemToReg;
    logic            Halted;
    logic            Error;
    // Registered result of the last EQ instruction, for future conditional ops.
    logic            EqFlag;

    modport master (
        output InstrReq, InstrAddr, ALUControl, RegWrite, RdAddr, RsAddr, Imm,
               MemRead, MemWrite, MemToReg, Halted, Error, EqFlag,
        input  InstrValid, Instr, Zero, MemAck
    );

    modport slave (
        input  InstrReq, InstrAddr, ALUControl, RegWrite, RdAddr, RsAddr, Imm,
               MemRead, MemWrite, MemToReg, Halted, Error, EqFlag,
        output InstrValid, Instr, Zero, MemAck
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit: fetches 16-bit instructions, sequences
// FETCH/DECODE/EXECUTE/MEM/WB and drives ALU, register-file and memory controls.
module alu_ctrl_fsm #(
    parameter int unsigned     PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst_n,
    alu_ctrl_fsm_if.master bus
);
    localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] OpNop   = 4'b0000;
    localparam logic [3:0] OpHalt  = 4'b0001;
    localparam logic [3:0] OpLoad  = 4'b0010;
    localparam logic [3:0] OpStore = 4'b0011;
    localparam logic [3:0] OpJump  = 4'b0100;
    localparam logic [3:0] OpEq    = 4'b0101;
    localparam logic [3:0] OpAdd   = 4'b1000;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e           state;
    logic [PC_W-1:0]  pc;
    logic [3:0]       op;
    logic [TMR_W-1:0] timer;
    logic             instr_req;
    logic [3:0]       alu_ctrl;
    logic             reg_write;
    logic [1:0]       rd_addr;
    logic [1:0]       rs_addr;
    logic [7:0]       imm;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             halted;
    logic             error;
    logic             eq_flag;

    logic [PC_W-1:0]  pc_inc;
    assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StFetch;
            pc         <= RESET_PC;
            op         <= OpNop;
            timer      <= '0;
            instr_req  <= 1'b0;
            alu_ctrl   <= 4'b0000;
            reg_write  <= 1'b0;
            rd_addr    <= 2'b00;
            rs_addr    <= 2'b00;
            imm        <= 8'h00;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
            eq_flag    <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    // The first cycle after reset raises the request; valid is only
                    // honoured once the request is visible.
                    if (!instr_req) begin
                        instr_req <= 1'b1;
                    end else if (bus.InstrValid) begin
                        instr_req <= 1'b0;
                        op        <= bus.Instr[15:12];
                        rd_addr   <= bus.Instr[11:10];
                        rs_addr   <= bus.Instr[9:8];
                        imm       <= bus.Instr[7:0];
                        state     <= StDecode;
                    end
                end
                StDecode: begin
                    case (op)
                        OpNop: begin
                            pc        <= pc_inc;
                            instr_req <= 1'b1;
                            state     <= StFetch;
                        end
                        OpHalt: begin
                            halted <= 1'b1;
                            state  <= StHalt;
                        end
                        OpJump: begin
                            pc        <= PC_W'(imm);
                            instr_req <= 1'b1;
                            state     <= StFetch;
                        end
                        OpLoad, OpStore: begin
                            alu_ctrl <= OpAdd;
                            state    <= StExecute;
                        end
                        default: begin
                            alu_ctrl <= op;
                            state    <= StExecute;
                        end
                    endcase
                end
                StExecute: begin
                    if (op == OpEq) begin
                        eq_flag <= ~bus.Zero;
                    end
                    timer <= '0;
                    if (op == OpLoad) begin
                        mem_read <= 1'b1;
                        state    <= StMem;
                    end else if (op == OpStore) begin
                        mem_write <= 1'b1;
                        state     <= StMem;
                    end else begin
                        reg_write <= 1'b1;
                        state     <= StWb;
                    end
                end
                StMem: begin
                    if (bus.MemAck) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (op == OpLoad) begin
                            mem_to_reg <= 1'b1;
                            reg_write  <= 1'b1;
                            state      <= StWb;
                        end else begin
                            pc        <= pc_inc;
                            instr_req <= 1'b1;
                            state     <= StFetch;
                        end
                    end else if (timer == TMR_W'(MEM_TIMEOUT - 1)) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        error     <= 1'b1;
                        halted    <= 1'b1;
                        state     <= StHalt;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StWb: begin
                    reg_write  <= 1'b0;
                    mem_to_reg <= 1'b0;
                    pc         <= pc_inc;
                    instr_req  <= 1'b1;
                    state      <= StFetch;
                end
                StHalt: begin
                    instr_req <= 1'b0;
                    reg_write <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    halted    <= 1'b1;
                end
                default: begin
                    state <= StHalt;
                end
            endcase
        end
    end

    assign bus.InstrReq   = instr_req;
    assign bus.InstrAddr  = pc;
    assign bus.ALUControl = alu_ctrl;
    assign bus.RegWrite   = reg_write;
    assign bus.RdAddr     = rd_addr;
    assign bus.RsAddr     = rs_addr;
    assign bus.Imm        = imm;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.Halted     = halted;
    assign bus.Error      = error;
    assign bus.EqFlag     = eq_flag;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: directed and random instructions against a
// per-instruction reference model of PC, latency and strobe counts.
module tb_alu_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_fsm_if #(.PC_W(8)) bus ();

    alu_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00), .MEM_TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] m_pc;
    logic [3:0] m_alu;
    logic       m_eq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, bus.InstrReq, 0);
        chk({tag, "_addr"}, bus.InstrAddr, 0);
        chk({tag, "_alu"}, bus.ALUControl, 0);
        chk({tag, "_strobes"}, {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg}, 0);
        chk({tag, "_flags"}, {bus.Halted, bus.Error}, 0);
        chk({tag, "_fields"}, {bus.RdAddr, bus.RsAddr, bus.Imm}, 0);
    endtask

    // Instruction class: 0 NOP, 1 HALT, 2 LOAD, 3 STORE, 4 JUMP, 5 ALU op.
    function automatic int kind(input logic [3:0] opc);
        if (opc >= 4'h5) return 5;
        return int'(opc);
    endfunction

    // ack_wait < 0 means the data memory never acknowledges.
    task automatic do_instr(input logic [15:0] ins, input int fwait, input int ack_wait,
                            input logic z);
        int n, k, lat, rw, m2r, mrd, mwr;
        int exp_lat, exp_rw, exp_mrd, exp_mwr;
        logic exp_halt, exp_err;
        k = kind(ins[15:12]);
        n = 0;
        while (bus.InstrReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", bus.InstrReq, 1);
        chk("fetch_addr", bus.InstrAddr, m_pc);
        repeat (fwait) @(negedge clk);
        chk("req_held", bus.InstrReq, 1);
        bus.Instr = ins;
        bus.InstrValid = 1'b1;
        bus.Zero = z;
        @(negedge clk);
        bus.InstrValid = 1'b0;
        bus.Instr = 16'($urandom);
        chk("req_drop", bus.InstrReq, 0);
        chk("dec_fields", {bus.RdAddr, bus.RsAddr, bus.Imm}, ins[11:0]);
        lat = 1; rw = 0; m2r = 0; mrd = 0; mwr = 0;
        while (bus.InstrReq !== 1'b1 && bus.Halted !== 1'b1 && lat < 60) begin
            if (bus.RegWrite === 1'b1) begin
                rw++;
                m2r = int'(bus.MemToReg);
            end
            if (bus.MemRead === 1'b1) mrd++;
            if (bus.MemWrite === 1'b1) mwr++;
            bus.MemAck = (mrd + mwr == ack_wait + 1) && (bus.MemRead || bus.MemWrite);
            @(negedge clk);
            lat++;
        end
        bus.MemAck = 1'b0;

        exp_rw = 0; exp_mrd = 0; exp_mwr = 0; exp_halt = 0; exp_err = 0;
        case (k)
            0: begin exp_lat = 2; m_pc = m_pc + 8'd1; end
            1: begin exp_lat = 2; exp_halt = 1; end
            4: begin exp_lat = 2; m_pc = ins[7:0]; end
            5: begin
                exp_lat = 4; exp_rw = 1; m_pc = m_pc + 8'd1; m_alu = ins[15:12];
                if (ins[15:12] == 4'h5) m_eq = ~z;
            end
            2: begin
                exp_lat = 5 + ack_wait; exp_rw = 1; exp_mrd = ack_wait + 1;
                m_pc = m_pc + 8'd1; m_alu = 4'b1000;
            end
            default: begin
                m_alu = 4'b1000;
                if (ack_wait < 0) begin
                    exp_lat = 18; exp_mwr = 15; exp_halt = 1; exp_err = 1;
                end else begin
                    exp_lat = 4 + ack_wait; exp_mwr = ack_wait + 1; m_pc = m_pc + 8'd1;
                end
            end
        endcase
        chk("latency", lat, exp_lat);
        chk("regwrite_cycles", rw, exp_rw);
        chk("memread_cycles", mrd, exp_mrd);
        chk("memwrite_cycles", mwr, exp_mwr);
        if (k == 2) chk("memtoreg_in_wb", m2r, 1);
        chk("alu_ctrl", bus.ALUControl, m_alu);
        chk("eq_flag", bus.EqFlag, m_eq);
        chk("memtoreg_after", bus.MemToReg, 0);
        chk("strobes_after", {bus.MemRead, bus.MemWrite, bus.RegWrite}, 0);
        chk("halted", bus.Halted, exp_halt);
        chk("error", bus.Error, exp_err);
        chk("next_addr", bus.InstrAddr, m_pc);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00; m_alu = 4'h0; m_eq = 1'b0;
    endtask

    initial begin
        logic [3:0] opc;
        int n;
        logic [7:0] frozen;
        bus.InstrValid = 1'b0;
        bus.Instr = 16'h0000;
        bus.Zero = 1'b0;
        bus.MemAck = 1'b0;
        m_pc = 8'h00; m_alu = 4'h0; m_eq = 1'b0;

        @(negedge clk);
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        do_instr(16'h8605, 3, 0, 1'b0);
        do_instr(16'h2410, 0, 4, 1'b0);
        do_instr(16'h5123, 1, 0, 1'b1);
        do_instr(16'h5123, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            opc = 4'($urandom_range(0, 15));
            if (opc == 4'h1) opc = 4'h0;
            do_instr({opc, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 5),
                     1'($urandom));
        end

        do_instr(16'h40F0, 0, 0, 1'b0);
        chk("jump_target", bus.InstrAddr, 8'hF0);

        // Reset while the fetch request is up.
        n = 0;
        while (bus.InstrReq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("pre_reset_req", bus.InstrReq, 1);
        apply_reset();
        do_instr(16'h0000, 2, 0, 1'b0);

        do_instr(16'h40FF, 0, 0, 1'b0);
        do_instr(16'h8605, 1, 0, 1'b0);
        chk("pc_wrap", bus.InstrAddr, 8'h00);

        do_instr(16'h3433, 0, -1, 1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.InstrReq !== 1'b0 || bus.MemWrite !== 1'b0) n++;
        end
        chk("timeout_quiet", n, 0);
        chk("timeout_sticky", {bus.Error, bus.Halted}, 2'b11);

        apply_reset();
        chk("error_cleared", bus.Error, 0);
        do_instr(16'h1000, 0, 0, 1'b0);
        frozen = bus.InstrAddr;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.InstrReq !== 1'b0 || bus.Halted !== 1'b1 || bus.InstrAddr !== frozen) n++;
        end
        chk("halt_frozen", n, 0);
        apply_reset();
        do_instr(16'h0000, 0, 0, 1'b0);
        chk("restart_addr", bus.InstrAddr, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
